// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
//   Shared definitions for the control unit's conditional-execution logic.
//   - cond_t    : ARM-style condition codes carried in instruction bits [31:28]
//   - flags_t   : architectural NZCV flag register layout
//   - FLAGW_*   : bit positions inside the decoder's 2-bit flag_w field
// -----------------------------------------------------------------------------
package cu_pkg;

  // Condition field encodings. 4'b1111 is not named; it is treated like AL.
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,  // Z set
    COND_NE = 4'b0001,  // Z clear
    COND_CS = 4'b0010,  // C set (unsigned higher or same)
    COND_CC = 4'b0011,  // C clear (unsigned lower)
    COND_MI = 4'b0100,  // N set (negative)
    COND_PL = 4'b0101,  // N clear (positive or zero)
    COND_VS = 4'b0110,  // V set (overflow)
    COND_VC = 4'b0111,  // V clear
    COND_HI = 4'b1000,  // C set and Z clear
    COND_LS = 4'b1001,  // C clear or Z set
    COND_GE = 4'b1010,  // N == V
    COND_LT = 4'b1011,  // N != V
    COND_GT = 4'b1100,  // Z clear and N == V
    COND_LE = 4'b1101,  // Z set or N != V
    COND_AL = 4'b1110   // always
  } cond_t;

  // Field order matches the {N,Z,C,V} packing used on every 4-bit flag bus.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // flag_w bit that enables the N,Z half / the C,V half of the update.
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage : cu_pkg

// File: rtl/condition_checker.sv
// -----------------------------------------------------------------------------
// condition_checker
//   Purely combinational evaluation of an instruction's condition field against
//   the currently held NZCV flags.
//
// Ports
//   cond     in  4  instruction condition field
//   flags    in  4  held flags {n,z,c,v}
//   cond_ex  out 1  1 when the instruction is allowed to execute
// -----------------------------------------------------------------------------
module condition_checker
  import cu_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       cond_ex
);

  logic n_eq_v;

  assign n_eq_v = (flags.n == flags.v);

  always_comb begin
    // NOTE: a default assignment ahead of the case keeps this block free of
    // inferred latches even if an arm is ever left without an assignment.
    cond_ex = 1'b1;
    unique case (cond)
      COND_EQ: cond_ex = flags.z;
      COND_NE: cond_ex = ~flags.z;
      COND_CS: cond_ex = flags.c;
      COND_CC: cond_ex = ~flags.c;
      COND_MI: cond_ex = flags.n;
      COND_PL: cond_ex = ~flags.n;
      COND_VS: cond_ex = flags.v;
      COND_VC: cond_ex = ~flags.v;
      COND_HI: cond_ex = flags.c & ~flags.z;
      COND_LS: cond_ex = ~flags.c | flags.z;
      COND_GE: cond_ex = n_eq_v;
      COND_LT: cond_ex = ~n_eq_v;
      COND_GT: cond_ex = ~flags.z & n_eq_v;
      COND_LE: cond_ex = flags.z | ~n_eq_v;
      // AL, the unnamed 4'b1111 and any unknown encoding all execute, so an
      // X on cond never turns into an X on the write enables.
      default: cond_ex = 1'b1;
    endcase
  end

endmodule : condition_checker

// File: rtl/conditional_flags_unit.sv
// -----------------------------------------------------------------------------
// conditional_flags_unit
//   Owner of the architectural NZCV flags. Evaluates the current instruction's
//   condition against the held flags, gates the decoder's write enables with the
//   result, updates the flags from the ALU when the instruction executes, and
//   keeps a registered copy of the condition result for multicycle sequencing.
//
// Parameters
//   RESET_FLAGS  {N,Z,C,V} loaded on reset
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous, active-low reset
//   en           in   1  0 = hold flags and cond_ex_q
//   flush        in   1  kill current instruction (clears cond_ex_q, no flag update)
//   instr_valid  in   1  current instruction is valid
//   cond         in   4  instruction condition field
//   flag_w       in   2  [1] update N,Z; [0] update C,V
//   alu_flags    in   4  {N,Z,C,V} produced by the ALU
//   pcs          in   1  decoder: instruction writes PC
//   reg_w        in   1  decoder: instruction writes register file
//   mem_w        in   1  decoder: instruction writes memory
//   no_write     in   1  decoder: compare-type op, suppress register write
//   flags        out  4  registered {N,Z,C,V}
//   cond_ex      out  1  condition result on the current (pre-update) flags
//   cond_ex_q    out  1  registered qualified condition result
//   pc_src       out  1  gated pcs
//   reg_write    out  1  gated reg_w
//   mem_write    out  1  gated mem_w
// -----------------------------------------------------------------------------
module conditional_flags_unit
  import cu_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       flush,
  input  logic       instr_valid,
  input  logic [3:0] cond,
  input  logic [1:0] flag_w,
  input  logic [3:0] alu_flags,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic [3:0] flags,
  output logic       cond_ex,
  output logic       cond_ex_q,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write
);

  flags_t flags_q;
  flags_t alu_f;
  logic   go;

  assign alu_f = flags_t'(alu_flags);

  condition_checker u_condition_checker (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  // An instruction "goes" when it is valid, not being killed and its condition
  // passes on the flags as they stand before this cycle's update.
  assign go = instr_valid & ~flush & cond_ex;

  assign pc_src    = pcs & go;
  assign reg_write = reg_w & ~no_write & go;
  assign mem_write = mem_w & go;
  assign flags     = flags_q;

  // Flag register. go already excludes flush, so a killed instruction can never
  // touch the flags; each half is written independently and otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= flags_t'(RESET_FLAGS);
    end else if (en && go) begin
      // NOTE: non-blocking assignments here so that cond_ex, computed from
      // flags_q in the same cycle, sees the old flags; the new value is
      // visible only after the edge.
      if (flag_w[FLAGW_NZ]) begin
        flags_q.n <= alu_f.n;
        flags_q.z <= alu_f.z;
      end
      if (flag_w[FLAGW_CV]) begin
        flags_q.c <= alu_f.c;
        flags_q.v <= alu_f.v;
      end
    end
  end

  // Registered condition result. flush wins over a stall so that a killed
  // instruction never leaves a stale "executing" marker behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_ex_q <= 1'b0;
    end else if (flush) begin
      cond_ex_q <= 1'b0;
    end else if (en) begin
      cond_ex_q <= instr_valid & cond_ex;
    end
  end

endmodule : conditional_flags_unit

// File: tb/tb_conditional_flags_unit.sv
// -----------------------------------------------------------------------------
// tb_conditional_flags_unit
//   Directed self-checking bench. Expected output vectors come from a small
//   reference model (or from literal constants for the headline cases) and go
//   through a queue that is popped when the DUT outputs are sampled.
//   Observed/expected vector layout: {flags[3:0], cond_ex, cond_ex_q,
//   pc_src, reg_write, mem_write}.
// -----------------------------------------------------------------------------
module tb_conditional_flags_unit;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       flush;
  logic       instr_valid;
  logic [3:0] cond;
  logic [1:0] flag_w;
  logic [3:0] alu_flags;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic       no_write;
  logic [3:0] flags;
  logic       cond_ex;
  logic       cond_ex_q;
  logic       pc_src;
  logic       reg_write;
  logic       mem_write;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];

  // Reference model state.
  logic [3:0] m_flags;
  logic       m_cq;

  conditional_flags_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .flush       (flush),
    .instr_valid (instr_valid),
    .cond        (cond),
    .flag_w      (flag_w),
    .alu_flags   (alu_flags),
    .pcs         (pcs),
    .reg_w       (reg_w),
    .mem_w       (mem_w),
    .no_write    (no_write),
    .flags       (flags),
    .cond_ex     (cond_ex),
    .cond_ex_q   (cond_ex_q),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .mem_write   (mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the bench only waits on its own clock, but never let it hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Condition evaluation written as the classic "base condition xor invert
  // bit" table rather than one case per code.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, b;
    if ($isunknown(c)) return 1'b1;
    {n, z, cc, v} = f;
    case (c[3:1])
      3'd0:    b = z;
      3'd1:    b = cc;
      3'd2:    b = n;
      3'd3:    b = v;
      3'd4:    b = cc & ~z;
      3'd5:    b = (n == v);
      3'd6:    b = ~z & (n == v);
      default: return 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  function automatic logic [8:0] model_vec();
    logic ce, g;
    ce = ref_cond(cond, m_flags);
    g  = instr_valid & ~flush & ce;
    return {m_flags, ce, m_cq, pcs & g, reg_w & ~no_write & g, mem_w & g};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {flags, cond_ex, cond_ex_q, pc_src, reg_write, mem_write};
  endfunction

  // Model update for one rising edge with the currently driven inputs.
  task automatic model_edge();
    logic g;
    g = instr_valid & ~flush & ref_cond(cond, m_flags);
    if (en && g) begin
      if (flag_w[1]) m_flags[3:2] = alu_flags[3:2];
      if (flag_w[0]) m_flags[1:0] = alu_flags[1:0];
    end
    if (flush)   m_cq = 1'b0;
    else if (en) m_cq = g;
  endtask

  task automatic check(input string tag, input logic [8:0] obs);
    logic [8:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%b expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, e);
      end
    end
  endtask

  // Checks against a literal value, padded into the 9-bit scoreboard slot.
  task automatic check_const(input string tag, input logic [8:0] obs, input logic [8:0] want);
    exp_q.push_back(want);
    check(tag, obs);
  endtask

  // One instruction cycle: drive after a falling edge, check combinational
  // outputs before the rising edge, then check the registered state after it.
  task automatic step(input string tag,
                      input logic en_i, input logic flush_i, input logic valid_i,
                      input logic [3:0] cond_i, input logic [1:0] fw_i,
                      input logic [3:0] alu_i,
                      input logic pcs_i, input logic regw_i, input logic memw_i,
                      input logic nw_i);
    en = en_i; flush = flush_i; instr_valid = valid_i; cond = cond_i;
    flag_w = fw_i; alu_flags = alu_i;
    pcs = pcs_i; reg_w = regw_i; mem_w = memw_i; no_write = nw_i;
    #1;
    exp_q.push_back(model_vec());
    check({tag, "_pre"}, obs_vec());
    @(posedge clk);
    model_edge();
    #1;
    exp_q.push_back(model_vec());
    check({tag, "_post"}, obs_vec());
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; instr_valid = 1'b0;
    cond = 4'b1110; flag_w = 2'b00; alu_flags = 4'b0000;
    pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
    m_flags = 4'b0000; m_cq = 1'b0;

    // 1. Reset state, no clock edge yet.
    #3;
    check_const("reset_flags", {5'b0, flags}, 9'd0);
    check_const("reset_cq", {8'b0, cond_ex_q}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. ADDS with AL sets NZCV, then EQ passes on Z=1.
    step("adds", 1, 0, 1, 4'b1110, 2'b11, 4'b0110, 0, 1, 0, 0);
    check_const("adds_flags", {5'b0, flags}, {5'b0, 4'b0110});
    step("eq_pass", 1, 0, 1, 4'b0000, 2'b00, 4'b0000, 1, 1, 0, 0);

    // 3. Partial write: only N,Z taken from the ALU.
    step("set1001", 1, 0, 1, 4'b1110, 2'b11, 4'b1001, 0, 0, 0, 0);
    step("partial", 1, 0, 1, 4'b1110, 2'b10, 4'b0110, 0, 0, 0, 0);
    check_const("partial_flags", {5'b0, flags}, {5'b0, 4'b0101});

    // 4. Failed condition blocks writes and the flag update.
    step("set1000", 1, 0, 1, 4'b1110, 2'b11, 4'b1000, 0, 0, 0, 0);
    en = 1; flush = 0; instr_valid = 1; cond = 4'b0000; flag_w = 2'b11;
    alu_flags = 4'b0111; pcs = 1; reg_w = 1; mem_w = 0; no_write = 0;
    #1;
    check_const("fail_gates", {7'b0, pc_src, reg_write}, 9'd0);
    @(negedge clk);
    m_flags = 4'b1000;
    m_cq = 1'b0;
    check_const("fail_flags", {5'b0, flags}, {5'b0, 4'b1000});

    // 5. Compare: no register write, flags still updated.
    step("cmp", 1, 0, 1, 4'b1110, 2'b11, 4'b0100, 0, 1, 0, 1);
    check_const("cmp_flags", {5'b0, flags}, {5'b0, 4'b0100});

    // 6. Stall holds flags and cond_ex_q; flush clears cond_ex_q even stalled.
    step("stall", 0, 0, 1, 4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0);
    check_const("stall_hold", {4'b0, flags, cond_ex_q}, {4'b0, 4'b0100, 1'b1});
    step("flush_stall", 0, 1, 1, 4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0);
    check_const("flush_cq", {8'b0, cond_ex_q}, 9'd0);
    step("flush_run", 1, 1, 1, 4'b1110, 2'b11, 4'b1111, 1, 1, 1, 0);
    check_const("flush_flags", {5'b0, flags}, {5'b0, 4'b0100});

    // 7. Sweep every condition code over a handful of flag patterns.
    for (int p = 0; p < 4; p++) begin
      logic [3:0] pats[4];
      pats = '{4'b0000, 4'b0110, 4'b1001, 4'b1011};
      step("load_pat", 1, 0, 1, 4'b1110, 2'b11, pats[p], 0, 0, 0, 0);
      for (int c = 0; c < 16; c++) begin
        step($sformatf("cond%0d_p%0d", c, p), 1, 0, 1, 4'(c), 2'b00,
             4'(c), 1, 1, 1, 0);
      end
    end

    // 8. Unknown condition field executes.
    step("cond_x", 1, 0, 1, 4'bxxxx, 2'b00, 4'b0000, 1, 0, 0, 0);

    // 9. Reset in the middle of an updating cycle, then a normal first edge.
    en = 1; flush = 0; instr_valid = 1; cond = 4'b1110; flag_w = 2'b11;
    alu_flags = 4'b1111; pcs = 0; reg_w = 0; mem_w = 0; no_write = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check_const("midreset", {4'b0, flags, cond_ex_q}, 9'd0);
    m_flags = 4'b0000;
    m_cq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", 1, 0, 1, 4'b1110, 2'b11, 4'b0011, 0, 1, 0, 0);
    check_const("post_reset_flags", {5'b0, flags}, {5'b0, 4'b0011});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_conditional_flags_unit
